sti_unpack: RTL

STI_UNPACK -- requirements
Module: sti_unpack

---
 rtl/dt_pkg.sv | 22 ++
 rtl/sti_shreg.sv | 47 ++++
 rtl/sti_unpack.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared constants and FSM encoding for the sti-to-res image unpacker.
package dt_pkg;

    localparam int IMG_W        = 128;
    localparam int PIX_PER_WORD = 16;
    localparam int TOTAL_PIX    = IMG_W * IMG_W;
    localparam int RES_AW       = $clog2(TOTAL_PIX);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_VFETCH = 3'd4;
    localparam logic [2:0] S_VLOAD  = 3'd5;
    localparam logic [2:0] S_VREAD  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    function automatic logic [RES_AW-1:0] pix_addr(input logic [9:0] word, input logic [3:0] k);
        return {word, k};
    endfunction

endpackage

// File: rtl/sti_shreg.sv
// 16-bit MSB-first load/shift register with its bit counter.
module sti_shreg
    import dt_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    shift_i,
    input  logic [PIX_PER_WORD-1:0] data_i,
    output logic                    msb_o,
    output logic                    msb_next_o,
    output logic [4:0]              cnt_o,
    output logic [4:0]              cnt_next_o
);

    logic [PIX_PER_WORD-1:0] shreg_q, shreg_d;
    logic [4:0]              cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[PIX_PER_WORD-2:0], 1'b0};
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state views let the parent register outputs for the cycle being entered.
    assign msb_o      = shreg_q[PIX_PER_WORD-1];
    assign msb_next_o = shreg_d[PIX_PER_WORD-1];
    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/sti_unpack.sv
// Unpacks 1-bit sti ROM words into byte pixels in res RAM, then optionally re-reads and counts mismatches.
module sti_unpack
    import dt_pkg::*;
#(
    parameter int WORDS  = 1024,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              sti_rd,
    output logic [9:0]        sti_addr,
    input  logic [15:0]       sti_di,
    output logic              res_wr,
    output logic              res_rd,
    output logic [RES_AW-1:0] res_addr,
    output logic [7:0]        res_do,
    input  logic [7:0]        res_di,
    output logic              done,
    output logic [14:0]       err_cnt
);

    logic [2:0]        state_q, state_d;
    logic [9:0]        word_q, word_d;
    logic              sti_rd_q, res_wr_q, res_rd_q, done_q;
    logic              sti_rd_d, res_wr_d, res_rd_d, done_d;
    logic [9:0]        sti_addr_q;
    logic [RES_AW-1:0] res_addr_q, res_addr_d;
    logic [7:0]        res_do_q, res_do_d;
    logic [7:0]        cap_q;
    logic              exp_q;
    logic [14:0]       err_cnt_q;
    logic              msb, msb_next, last_word, load, shift;
    logic [4:0]        cnt, cnt_next;

    assign last_word = (word_q == 10'(WORDS - 1));
    assign load      = (state_q == S_LOAD) || (state_q == S_VLOAD);
    assign shift     = (state_q == S_WRITE) || (state_q == S_VREAD);

    sti_shreg u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .shift_i   (shift),
        .data_i    (sti_di),
        .msb_o     (msb),
        .msb_next_o(msb_next),
        .cnt_o     (cnt),
        .cnt_next_o(cnt_next)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                word_d  = '0;
            end
            S_FETCH:  state_d = S_LOAD;
            S_LOAD:   state_d = S_WRITE;
            S_WRITE: begin
                if (cnt == 5'd15) begin
                    if (last_word) begin
                        word_d  = '0;
                        state_d = (VERIFY != 0) ? S_VFETCH : S_DONE;
                    end else begin
                        word_d  = word_q + 10'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_VFETCH: state_d = S_VLOAD;
            S_VLOAD:  state_d = S_VREAD;
            S_VREAD: begin
                if (cnt == 5'd16) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_d  = word_q + 10'd1;
                        state_d = S_VFETCH;
                    end
                end
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up with that state's cycle.
    always_comb begin
        sti_rd_d   = (state_d == S_FETCH) || (state_d == S_VFETCH);
        res_wr_d   = (state_d == S_WRITE);
        res_rd_d   = (state_d == S_VREAD) && !cnt_next[4];
        res_addr_d = res_addr_q;
        if (res_wr_d || res_rd_d) begin
            res_addr_d = pix_addr(word_d, cnt_next[3:0]);
        end
        res_do_d   = res_wr_d ? {7'b0, msb_next} : '0;
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= '0;
            res_wr_q   <= 1'b0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            done_q     <= 1'b0;
            cap_q      <= '0;
            exp_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            sti_rd_q   <= sti_rd_d;
            sti_addr_q <= word_d;
            res_wr_q   <= res_wr_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
            done_q     <= done_d;
            // res_di for read k is held one cycle and compared while read k+1 is in flight.
            if (state_q == S_VREAD && !cnt[4]) begin
                cap_q <= res_di;
                exp_q <= msb;
            end
            if (state_q == S_VREAD && cnt != 5'd0 &&
                cap_q != {7'b0, exp_q} && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 15'd1;
            end
        end
    end

    assign sti_rd   = sti_rd_q;
    assign sti_addr = sti_addr_q;
    assign res_wr   = res_wr_q;
    assign res_rd   = res_rd_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;

endmodule
